fpu_pre_norm_addsub: RTL
========================

# fpu_pre_norm_addsub

Front end of the single-precision add/subtract datapath. Unpacks two IEEE-754 binary32 operands, aligns the smaller significand to the larger exponent with a sticky bit, and performs the effective add or subtract. It emits the 28-bit unnormalized significand, exponent and sign that `post_norm_addsub` consumes. The block is a 2-stage pipeline with valid/ready flow control.

## Interface
- FP_WIDTH, 32, operand width
- FRAC_WIDTH, 23, stored fraction bits
- EXP_WIDTH, 8, exponent bits
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  input operands valid
- ready_o  out  1  block accepts input this cycle
- opa_i, opb_i  in  32  operands
- fpu_op_i  in  1  0 = add, 1 = subtract (opa − opb)
- rmode_i  in  2  rounding mode, same encoding as post-norm; 11 = toward −inf
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- fract_28_o  out  28  [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky
- exp_o  out  8  larger raw exponent field
- sign_o  out  1  result sign
- opa_o, opb_o, fpu_op_o, rmode_o  out  32/32/1/2  pass-through, aligned with the result

## Operation
- Unpack:
  - hidden bit = (exp != 0).
  - Effective exponent = exp, or 1 when exp == 0.
  - Significand S = {1'b0, hidden, frac, 3'b000}.
- Exponent compare: the larger effective exponent selects the "big" operand. d = difference.
  - On a tie, the big operand is chosen by fraction magnitude (opa when equal).
- Align: shift the small S right by d.
  - Bit 0 of the result = bit 0 of the shifted value OR any bit shifted out.
  - d ≥ 27: result = 28'h1 if the small S is nonzero, else 0.
- Effective subtract: eff_sub = fpu_op_i ^ sa ^ sb.
- Add (eff_sub = 0): fract = Sbig + Salign. sign = sa.
- Subtract (eff_sub = 1): fract = Sbig − Salign, never negative.
  - sign = sign of the big operand; opb's sign is inverted when fpu_op_i = 1.
- Exact zero with eff_sub = 1: sign_o = (rmode == 2'b11).
- Both operands zero with eff_sub = 0: sign_o = sa.
- exp_o = max(raw exp fields). Two denormals give exp_o = 0.
- Inf/NaN: exponent FF is processed as a normal value. Operands are passed through and the post-norm stage resolves special values.

## Timing
- Stages:
  - Stage 1 registers the unpacked fields, the aligned significands, exp, eff_sub and the pass-through fields.
  - Stage 2 registers the add/sub result and sign.
- en = !valid_o || ready_i. ready_o = en. Both stages advance only when en = 1.
- Latency: valid_i accepted in cycle N → valid_o in N+2 when no stall. Throughput is 1 per cycle.
- Stall (valid_o && !ready_i): all outputs and stage-1 contents hold stable and ready_o = 0. No transaction is lost or duplicated, and order is preserved.
- valid_i high while ready_o = 0: the input is not taken and the source must hold it.
- Reset: valid_o = 0, stage-1 valid = 0, and all data outputs = 0 on the next edge. In-flight transactions are discarded. ready_o = 1 in the first cycle after reset.
- valid_i during rst_i: ignored.

## Structure
- `fpu_pkg`: FP_WIDTH, FRAC_WIDTH, EXP_WIDTH, FRACT28_W = 28, op codes (OP_ADD, OP_SUB), rounding-mode constants.
- Sub-module `fpu_align_shift`: combinational right shifter, 28-bit value plus 5-bit amount in, shifted value with sticky OR into bit 0 out, saturating at d ≥ 27.
- Top: two pipeline register banks, compare/swap logic, and the 28-bit add/sub.

## Test plan
- 3F800000 + 3F800000, op 0 → fract_28_o = 0x8000000, exp_o = 0x7F, sign_o = 0, valid_o 2 cycles after accept.
- 40400000 − 40A00000 (3 − 5) → fract_28_o = 0x2000000, exp_o = 0x81, sign_o = 1.
- 3F800000 + 30800000 (d = 30) → fract_28_o = 0x4000001, exp_o = 0x7F.
- 3F800000 − 3F800000: rmode 00 → fract 0, sign 0. Rerun with rmode 11 → sign 1.
- Back-to-back stream of 4 ops, ready_i low for 3 cycles mid-stream:
  - ready_o drops while valid_o is stalled.
  - Outputs stay frozen during the stall.
  - All 4 results arrive once each, in order.
- 00000001 + 00000001 → fract_28_o = 0x10, exp_o = 0.
- Reset asserted with 2 ops in flight → valid_o = 0 next cycle and no stale result emitted afterwards.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, stage records and operand unpacking for the binary32
// add/subtract front end.
package fpu_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int FRAC_WIDTH = 23;
    localparam int EXP_WIDTH  = 8;
    localparam int FRACT28_W  = 28;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [1:0] RM_NEAREST = 2'b00;
    localparam logic [1:0] RM_ZERO    = 2'b01;
    localparam logic [1:0] RM_POS_INF = 2'b10;
    localparam logic [1:0] RM_NEG_INF = 2'b11;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp_raw;
        logic [EXP_WIDTH-1:0] exp_eff;
        logic [FRACT28_W-1:0] sig;
    } unpacked_t;

    typedef struct packed {
        logic                 valid;
        logic [FRACT28_W-1:0] sig_big;
        logic [FRACT28_W-1:0] sig_small;
        logic [EXP_WIDTH-1:0] exp_max;
        logic                 sign_big;
        logic                 eff_sub;
        logic [1:0]           rmode;
        logic [FP_WIDTH-1:0]  opa;
        logic [FP_WIDTH-1:0]  opb;
        logic                 fpu_op;
    } stage1_t;

    typedef struct packed {
        logic                 valid;
        logic [FRACT28_W-1:0] fract;
        logic [EXP_WIDTH-1:0] exp_max;
        logic                 sign;
        logic [1:0]           rmode;
        logic [FP_WIDTH-1:0]  opa;
        logic [FP_WIDTH-1:0]  opb;
        logic                 fpu_op;
    } stage2_t;

    // Denormals use an effective exponent of 1 and no hidden bit.
    function automatic unpacked_t unpack(input logic [FP_WIDTH-1:0] op);
        unpacked_t u;
        logic      hidden;
        hidden    = |op[FP_WIDTH-2 -: EXP_WIDTH];
        u.sign    = op[FP_WIDTH-1];
        u.exp_raw = op[FP_WIDTH-2 -: EXP_WIDTH];
        u.exp_eff = hidden ? op[FP_WIDTH-2 -: EXP_WIDTH] : 8'd1;
        u.sig     = {1'b0, hidden, op[FRAC_WIDTH-1:0], 3'b000};
        return u;
    endfunction

endpackage

// File: rtl/fpu_pre_norm_addsub_if.sv
// Operand-in / unnormalized-result-out bus for the add/sub front end.
interface fpu_pre_norm_addsub_if;
    import fpu_pkg::*;

    logic                 valid_i;
    logic                 ready_o;
    logic [FP_WIDTH-1:0]  opa_i;
    logic [FP_WIDTH-1:0]  opb_i;
    logic                 fpu_op_i;
    logic [1:0]           rmode_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [FRACT28_W-1:0] fract_28_o;
    logic [EXP_WIDTH-1:0] exp_o;
    logic                 sign_o;
    logic [FP_WIDTH-1:0]  opa_o;
    logic [FP_WIDTH-1:0]  opb_o;
    logic                 fpu_op_o;
    logic [1:0]           rmode_o;

    modport master (
        output valid_i, opa_i, opb_i, fpu_op_i, rmode_i, ready_i,
        input  ready_o, valid_o, fract_28_o, exp_o, sign_o,
               opa_o, opb_o, fpu_op_o, rmode_o
    );

    modport slave (
        input  valid_i, opa_i, opb_i, fpu_op_i, rmode_i, ready_i,
        output ready_o, valid_o, fract_28_o, exp_o, sign_o,
               opa_o, opb_o, fpu_op_o, rmode_o
    );

endinterface

// File: rtl/fpu_align_shift.sv
// Right shifter for significand alignment; bits shifted out collapse into a
// sticky bit in position 0. Amounts of 27 and above leave only the sticky.
module fpu_align_shift
    import fpu_pkg::*;
(
    input  logic [FRACT28_W-1:0] val_i,
    input  logic [4:0]           shamt_i,
    output logic [FRACT28_W-1:0] val_o
);

    logic [FRACT28_W-1:0] shifted;
    logic [FRACT28_W-1:0] lost_mask;

    always_comb begin
        shifted   = val_i >> shamt_i;
        lost_mask = ~({FRACT28_W{1'b1}} << shamt_i);
        if (shamt_i >= 5'd27) begin
            val_o = {{(FRACT28_W-1){1'b0}}, |val_i};
        end else begin
            val_o = {shifted[FRACT28_W-1:1], shifted[0] | (|(val_i & lost_mask))};
        end
    end

endmodule

// File: rtl/fpu_pre_norm_addsub.sv
// Two-stage add/sub front end: unpack, compare/swap and align in stage 1,
// effective add/subtract and result sign in stage 2.
module fpu_pre_norm_addsub
    import fpu_pkg::*;
(
    input logic                  clk_i,
    input logic                  rst_i,
    fpu_pre_norm_addsub_if.slave bus
);

    stage1_t s1_d, s1_q;
    stage2_t s2_d, s2_q;

    unpacked_t            ua, ub, u_big, u_small;
    logic                 a_big;
    logic                 en;
    logic [EXP_WIDTH-1:0] exp_diff;
    logic [4:0]           shamt;
    logic [FRACT28_W-1:0] sig_aligned;
    logic [FRACT28_W-1:0] fract_res;

    assign en = !s2_q.valid || bus.ready_i;

    // Equal exponents fall back to significand magnitude so the subtract
    // never goes negative; exact ties keep opa as the big operand.
    always_comb begin
        ua       = unpack(bus.opa_i);
        ub       = unpack(bus.opb_i);
        a_big    = (ua.exp_eff > ub.exp_eff) ||
                   ((ua.exp_eff == ub.exp_eff) && (ua.sig >= ub.sig));
        u_big    = a_big ? ua : ub;
        u_small  = a_big ? ub : ua;
        exp_diff = u_big.exp_eff - u_small.exp_eff;
        shamt    = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
    end

    fpu_align_shift u_align (
        .val_i   (u_small.sig),
        .shamt_i (shamt),
        .val_o   (sig_aligned)
    );

    always_comb begin
        s1_d = s1_q;
        if (en) begin
            s1_d.valid = bus.valid_i;
            if (bus.valid_i) begin
                s1_d.sig_big   = u_big.sig;
                s1_d.sig_small = sig_aligned;
                s1_d.exp_max   = (ua.exp_raw > ub.exp_raw) ? ua.exp_raw : ub.exp_raw;
                s1_d.sign_big  = a_big ? ua.sign : (ub.sign ^ bus.fpu_op_i);
                s1_d.eff_sub   = bus.fpu_op_i ^ ua.sign ^ ub.sign;
                s1_d.rmode     = bus.rmode_i;
                s1_d.opa       = bus.opa_i;
                s1_d.opb       = bus.opb_i;
                s1_d.fpu_op    = bus.fpu_op_i;
            end
        end
    end

    always_comb begin
        fract_res = s1_q.eff_sub ? (s1_q.sig_big - s1_q.sig_small)
                                 : (s1_q.sig_big + s1_q.sig_small);
        s2_d = s2_q;
        if (en) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.fract   = fract_res;
                s2_d.exp_max = s1_q.exp_max;
                // An exact cancellation is +0 except when rounding toward -inf.
                s2_d.sign    = (s1_q.eff_sub && (fract_res == '0)) ?
                               (s1_q.rmode == RM_NEG_INF) : s1_q.sign_big;
                s2_d.rmode   = s1_q.rmode;
                s2_d.opa     = s1_q.opa;
                s2_d.opb     = s1_q.opb;
                s2_d.fpu_op  = s1_q.fpu_op;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign bus.ready_o    = en;
    assign bus.valid_o    = s2_q.valid;
    assign bus.fract_28_o = s2_q.fract;
    assign bus.exp_o      = s2_q.exp_max;
    assign bus.sign_o     = s2_q.sign;
    assign bus.opa_o      = s2_q.opa;
    assign bus.opb_o      = s2_q.opb;
    assign bus.fpu_op_o   = s2_q.fpu_op;
    assign bus.rmode_o    = s2_q.rmode;

endmodule
